// File: rtl/fft_peak_detector.sv
// rtl/fft_peak_detector.sv - L1-magnitude peak and threshold search over one FFT output frame
// Two-stage pipeline: stage 1 registers bin/mag/last, stage 2 updates the running search.
module fft_peak_detector #(
   parameter int N           = 32,
   parameter int DW          = 32,
   parameter int SCALE_SHIFT = 10,
   parameter int THRESH      = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 in_first,
   input  logic [DW-1:0]        in_real,
   input  logic [DW-1:0]        in_imag,
   output logic                 busy,
   output logic                 peak_valid,
   output logic [$clog2(N)-1:0] peak_bin,
   output logic [DW:0]          peak_mag,
   output logic                 peak_found,
   output logic [$clog2(N)-1:0] first_bin,
   output logic                 frame_err
);

   localparam int BW = $clog2(N);
   localparam int MW = DW + 1;
   localparam logic [BW-1:0] LAST_BIN = BW'(N - 1);
   localparam logic [BW-1:0] BIN_ONE  = BW'(1);
   localparam logic [DW-1:0] DW_ONE   = DW'(1);
   localparam logic [MW-1:0] THRESH_V = MW'(THRESH);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t        state, state_nxt;
   logic [BW-1:0] cnt, cnt_nxt;
   logic          accept, abort_now, last_now;
   logic [BW-1:0] bin_now;

   logic [DW-1:0] abs_re, abs_im;
   logic [MW-1:0] mag_now;

   logic          s1_valid, s1_first, s1_last, s1_abort;
   logic [BW-1:0] s1_bin;
   logic [MW-1:0] s1_mag;
   logic          s1_in_win, s1_over;

   logic          s2_last;
   logic [MW-1:0] run_max;
   logic [BW-1:0] run_bin;
   logic          run_found;
   logic [BW-1:0] run_first;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      abort_now = 1'b0;
      last_now  = 1'b0;
      bin_now   = cnt;
      case (state)
         IDLE: begin
            if (in_valid && in_first) begin
               accept    = 1'b1;
               bin_now   = '0;
               cnt_nxt   = BIN_ONE;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               accept = 1'b1;
               if (in_first) begin
                  // restart: the sample becomes bin 0 of a fresh frame
                  abort_now = 1'b1;
                  bin_now   = '0;
                  cnt_nxt   = BIN_ONE;
               end else if (cnt == LAST_BIN) begin
                  last_now  = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + BIN_ONE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == ACCUM);

   // negating the most negative value wraps to 2^(DW-1), which is correct unsigned
   assign abs_re  = in_real[DW-1] ? (~in_real) + DW_ONE : in_real;
   assign abs_im  = in_imag[DW-1] ? (~in_imag) + DW_ONE : in_imag;
   assign mag_now = {1'b0, abs_re} + {1'b0, abs_im};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_abort <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_bin   <= '0;
         s1_mag   <= '0;
      end else begin
         s1_valid <= accept;
         s1_abort <= abort_now;
         if (accept) begin
            s1_first <= (bin_now == '0);
            s1_last  <= last_now;
            s1_bin   <= bin_now;
            s1_mag   <= mag_now;
         end
      end
   end

   assign s1_in_win = (s1_bin != '0) && !s1_bin[BW-1];
   assign s1_over   = (s1_mag >> SCALE_SHIFT) > THRESH_V;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_last   <= 1'b0;
         run_max   <= '0;
         run_bin   <= '0;
         run_found <= 1'b0;
         run_first <= '0;
      end else begin
         s2_last <= s1_valid && s1_last;
         if (s1_valid) begin
            if (s1_first) begin
               run_max   <= '0;
               run_bin   <= BIN_ONE;
               run_found <= 1'b0;
               run_first <= '0;
            end else if (s1_in_win) begin
               // strict compare keeps the lowest bin on ties
               if (s1_mag > run_max) begin
                  run_max <= s1_mag;
                  run_bin <= s1_bin;
               end
               if (!run_found && s1_over) begin
                  run_found <= 1'b1;
                  run_first <= s1_bin;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         peak_valid <= 1'b0;
         frame_err  <= 1'b0;
         peak_bin   <= '0;
         peak_mag   <= '0;
         peak_found <= 1'b0;
         first_bin  <= '0;
      end else begin
         peak_valid <= s2_last;
         frame_err  <= s1_abort;
         if (s2_last) begin
            peak_bin   <= run_bin;
            peak_mag   <= run_max;
            peak_found <= run_found;
            first_bin  <= run_first;
         end
      end
   end

endmodule

// File: doc/fft_peak_detector.md
Name: fft_peak_detector

Overview:
- Downstream of the FFT core (`fft_dit`). Consumes its serial complex output stream, one bin per accepted sample, natural bin order, N bins per frame.
- Computes an L1 magnitude per bin: |re| + |im|.
- Over the positive-frequency bins 1..N/2-1, finds:
  - the dominant bin and its magnitude;
  - the lowest-indexed bin whose scaled magnitude exceeds a threshold.
- Reports both once per frame. This replaces ad-hoc post-FFT threshold logic with a clocked, streaming stage.

Parameters:
- N, 32, FFT length in bins; power of two, at least 4.
- DW, 32, width of the two's-complement real/imag input samples.
- SCALE_SHIFT, 10, right shift applied to the magnitude before the threshold compare.
- THRESH, 20, unsigned threshold; a bin qualifies when (mag >> SCALE_SHIFT) > THRESH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid this cycle.
- in_first  in  1  qualifies in_valid; marks bin 0 of a frame.
- in_real  in  DW  bin real part, two's complement.
- in_imag  in  DW  bin imaginary part, two's complement.
- busy  out  1  high while a frame is being accumulated.
- peak_valid  out  1  one-cycle pulse; result outputs are updated.
- peak_bin  out  log2(N)  index of the maximum-magnitude bin in 1..N/2-1.
- peak_mag  out  DW+1  unsigned L1 magnitude of peak_bin.
- peak_found  out  1  at least one bin in 1..N/2-1 exceeded the threshold.
- first_bin  out  log2(N)  lowest bin in 1..N/2-1 exceeding the threshold; 0 if none.
- frame_err  out  1  one-cycle pulse; the current frame was aborted.

Behaviour:
- Reset (asynchronous, reset=0):
  - all outputs 0, state IDLE, bin counter 0;
  - the pipeline is flushed;
  - a partially accumulated frame is discarded and never reported.
- Absolute value: |x| computed in DW unsigned bits, with no saturation. x = -2^(DW-1) gives 2^(DW-1).
- Magnitude: mag = |re| + |im| in DW+1 bits, with no overflow.
- Stage 1 registers bin index, mag and a last flag on each accepted sample.
- Stage 2 performs the compare/update.
- State IDLE:
  - in_valid && in_first: go to ACCUM, bin counter = 1, sample taken as bin 0.
  - in_valid without in_first: ignored, no error.
- State ACCUM:
  - each in_valid advances the bin counter;
  - the sample at counter N-1 is tagged last, then return to IDLE.
- Back-to-back frames: in_first may arrive on the cycle after the last sample, with no gap.
- in_first in ACCUM:
  - the current frame is aborted and frame_err pulses 1 cycle later;
  - the new sample becomes bin 0 of a new frame; the aborted frame produces no peak_valid.
- Gaps: in_valid=0 cycles inside a frame are permitted; the counter holds.
- busy = (state == ACCUM).
- Search window: bins 0 and N/2..N-1 are tracked through the pipeline but never update any result.
- Peak selection:
  - strict greater-than compare, so on a tie the lowest bin index wins;
  - running max initialised to 0 at frame start;
  - if all window magnitudes are 0, peak_bin=1 and peak_mag=0.
- Threshold: the first qualifying bin in ascending order is latched. If none qualifies, peak_found=0 and first_bin=0.
- Latency: peak_valid asserts exactly 2 cycles after the clock edge that accepted bin N-1.
- Output update: peak_bin, peak_mag, peak_found and first_bin update on the same edge as peak_valid, and hold until the next peak_valid or reset.
- Running accumulators belong to the in-flight frame only. A new frame never corrupts the held outputs of the previous one.
- Expected size: 150-250 lines of RTL.

Test Plan:
- Single tone: one frame, N=32, bin 4 = (20480, -4096), all other bins 0.
  - peak_valid 2 cycles after bin 31;
  - peak_bin=4, peak_mag=24576, peak_found=1, first_bin=4.
- Weak tone plus masked regions: bin 5 = (4096, 2048), bin 0 = (0x7FFFFFFF, 0), bin 20 = (1000000, 0).
  - Bin 5 mag 6144, scaled 6, is below THRESH.
  - Expected: peak_bin=5, peak_mag=6144, peak_found=0, first_bin=0. DC and mirror bins are ignored.
- Tie and threshold ordering: bins 3 and 7 both (30720, 0); bin 2 = (21504, 0), scaled 21.
  - Expected: peak_bin=3, peak_mag=30720, first_bin=2, peak_found=1.
- Extreme negative input: bin 6 real = 0x80000000, imag = 0xFFFFFFFF.
  - Expected: peak_mag=2147483649, peak_bin=6.
- Abort and recovery: in_first reasserted at bin 12 of frame A.
  - frame_err pulses once; no report for A; frame B (tone at bin 9) reports peak_bin=9.
  - Repeat with reset=0 for one cycle mid-frame: no peak_valid, all outputs 0; the next full frame reports normally.
- Back-to-back frames with random in_valid gaps:
  - exactly one peak_valid per frame, each correct against a software L1 model;
  - held outputs stable between pulses.
